// File: rtl/arm_rf_pkg.sv
// Shared widths and write-port sequencer states for the register-file write arbiter.
package arm_rf_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie.
module rf_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    // ptr = 0 favours requester 0, ptr = 1 favours requester 1
    logic ptr;

    always_comb begin
        grant0 = en & valid0 & (~valid1 | ~ptr);
        grant1 = en & valid1 & (~valid0 |  ptr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (grant0 | grant1) begin
            ptr <= grant0;
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Latch register-file write port: arbitrates two write-back sources and sequences
// a glitch-free one-hot latch enable pulse (SETUP -> ENABLE -> HOLD).
module rf_wport_arbiter #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic                flush,
    output logic [DATA_W-1:0]   lat_data,
    output logic [NUM_REGS-1:0] lat_wen,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    import arm_rf_pkg::*;

    // Handshake: a request transfers on the rising edge closing a cycle in which
    // reqN_valid and reqN_ready are both high; ready is only offered in IDLE.
    state_t              state;
    state_t              next_state;
    logic                arb_en;
    logic                grant0;
    logic                grant1;
    logic                take;
    logic [ADDR_W-1:0]   addr_q;
    logic [NUM_REGS-1:0] wen_d;

    assign arb_en = (state == IDLE) & ~flush & ~rst;

    rf_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (arb_en),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign take       = grant0 | grant1;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (take) next_state = SETUP;
            SETUP:   next_state = flush ? IDLE : ENABLE;
            ENABLE:  next_state = HOLD;
            HOLD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Enable is decoded one cycle early and registered so the latch gates see a clean edge.
    always_comb begin
        wen_d = '0;
        if (next_state == ENABLE) wen_d[addr_q] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            lat_data <= '0;
            lat_wen  <= '0;
        end else begin
            state   <= next_state;
            lat_wen <= wen_d;
            if (take) begin
                addr_q   <= grant0 ? req0_addr : req1_addr;
                lat_data <= grant0 ? req0_data : req1_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed table, corner sequences, and a random run
// against a cycle-numbered scheduling model.
module tb_rf_wport_arbiter;

    import arm_rf_pkg::*;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr  = '0;
    logic [DW-1:0] req0_data  = '0;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr  = '0;
    logic [DW-1:0] req1_data  = '0;
    logic          req0_ready;
    logic          req1_ready;
    logic          flush = 1'b0;
    logic [DW-1:0] lat_data;
    logic [NR-1:0] lat_wen;
    logic          busy;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    rf_wport_arbiter #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .flush      (flush),
        .lat_data   (lat_data),
        .lat_wen    (lat_wen),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        flush = 1'b0;
    endtask

    // Leaves the bench just after the edge that follows reset release... minus one:
    // release happens 1 time unit after a posedge, so the next posedge is the first usable one.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Continuous enable-pulse properties
    logic [NR-1:0] prev_wen = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_wen = '0;
        end else begin
            chk("wen_onehot0", 32'($onehot0(lat_wen)), 32'd1);
            if (lat_wen != '0) begin
                chk("wen_consecutive", 32'(prev_wen), 32'd0);
                chk("wen_state", 32'(dbg_state), 32'(ENABLE));
            end
            prev_wen = lat_wen;
        end
    end

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          fl;
        logic          e_r0;
        logic          e_r1;
        logic          e_busy;
        logic [NR-1:0] e_wen;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs[13];

    // Random-run model: everything is expressed as cycle numbers of future events.
    int m_free_at, m_acc_c, m_pulse_c, m_pulse_a, m_ptr;
    logic [DW-1:0] m_data;

    initial begin
        // single write, flush during ENABLE/HOLD, flush in IDLE
        vecs[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0};
        vecs[1]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h100};
        vecs[7]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 32'h100};
        vecs[8]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h100};
        vecs[9]  = '{1'b1, 4'd4, 32'hAA, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h100};
        vecs[10] = '{1'b1, 4'd4, 32'hAA, 1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h100};
        vecs[11] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'hAA};
        vecs[12] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 32'hAA};

        // reset state, sampled while rst is still high
        idle_inputs();
        req0_valid = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wen", 32'(lat_wen), 32'd0);
        chk("rst_data", lat_data, 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
            req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
            flush = vecs[i].fl;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("tbl%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].e_r1));
            chk($sformatf("tbl%0d_busy", i),   32'(busy),       32'(vecs[i].e_busy));
            chk($sformatf("tbl%0d_wen", i),    32'(lat_wen),    32'(vecs[i].e_wen));
            chk($sformatf("tbl%0d_data", i),   lat_data,        vecs[i].e_data);
            next_cycle();
        end

        // contention: grants alternate req0, req1, req0 four cycles apart
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'h22;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_ready0", i), 32'(req0_ready), 32'((i == 0) || (i == 8)));
            chk($sformatf("rr%0d_ready1", i), 32'(req1_ready), 32'(i == 4));
            chk($sformatf("rr%0d_wen", i), 32'(lat_wen),
                (i == 2 || i == 10) ? 32'h2 : (i == 6) ? 32'h4 : 32'h0);
            next_cycle();
        end

        // flush in SETUP cancels the write; req1 is taken again once back in IDLE
        do_reset();
        req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 32'h55;
        @(negedge clk);
        chk("fs_accept", 32'(req1_ready), 32'd1);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("fs_setup_busy", 32'(busy), 32'd1);
        chk("fs_setup_ready", 32'(req1_ready), 32'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("fs_nopulse", 32'(lat_wen), 32'd0);
        chk("fs_idle", 32'(busy), 32'd0);
        chk("fs_reaccept", 32'(req1_ready), 32'd1);
        next_cycle();
        req1_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("fs_pulse", 32'(lat_wen), 32'h20);
        next_cycle();

        // asynchronous reset in the middle of the ENABLE cycle
        do_reset();
        req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 32'h77;
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("ar_enable", 32'(lat_wen), 32'h80);
        #2 rst = 1'b1;
        #1;
        chk("ar_wen", 32'(lat_wen), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_data", lat_data, 32'd0);
        next_cycle();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd9; req0_data = 32'h99;
        @(negedge clk);
        chk("ar_first_edge", 32'(req0_ready), 32'd1);
        next_cycle();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("ar_no_retry", 32'(lat_wen), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("ar_new_pulse", 32'(lat_wen), 32'h200);
        next_cycle();

        // random run against the scheduling model
        do_reset();
        m_free_at = 0; m_acc_c = -10; m_pulse_c = -1; m_pulse_a = 0; m_ptr = 0; m_data = '0;
        for (int c = 0; c < 400; c++) begin
            logic e_r0, e_r1, idle;
            logic [NR-1:0] e_wen;
            logic [NR-1:0] one;
            req0_valid = ($urandom_range(0, 99) < 60);
            req1_valid = ($urandom_range(0, 99) < 60);
            req0_addr  = AW'($urandom_range(0, NR - 1));
            req1_addr  = AW'($urandom_range(0, NR - 1));
            req0_data  = $urandom;
            req1_data  = $urandom;
            flush      = ($urandom_range(0, 99) < 15);
            @(negedge clk);
            idle = (c >= m_free_at);
            e_r0 = 1'b0;
            e_r1 = 1'b0;
            if (idle && !flush) begin
                if (req0_valid && (!req1_valid || m_ptr == 0)) e_r0 = 1'b1;
                else if (req1_valid) e_r1 = 1'b1;
            end
            one = 1;
            e_wen = (c == m_pulse_c) ? (one << m_pulse_a) : '0;
            chk("rnd_ready0", 32'(req0_ready), 32'(e_r0));
            chk("rnd_ready1", 32'(req1_ready), 32'(e_r1));
            chk("rnd_busy", 32'(busy), 32'(!idle));
            chk("rnd_wen", 32'(lat_wen), 32'(e_wen));
            chk("rnd_data", lat_data, m_data);
            if (e_r0 || e_r1) begin
                m_acc_c   = c;
                m_free_at = c + 4;
                m_pulse_c = c + 2;
                m_pulse_a = e_r0 ? int'(req0_addr) : int'(req1_addr);
                m_data    = e_r0 ? req0_data : req1_data;
                m_ptr     = e_r0 ? 1 : 0;
            end else if (flush && c == m_acc_c + 1) begin
                m_pulse_c = -1;
                m_free_at = c + 1;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
